// File: rtl/acm_pkg.sv
// Shared widths, FSM encoding and word-FIFO entry layout for the muacm IN-pipe packer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package acm_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;
    localparam int NB_W   = 2;

    // Serializer states
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    // FIFO entry layout: {last, nbytes, data}
    localparam int ENT_DATA_LSB = 0;
    localparam int ENT_NB_LSB   = WORD_W;
    localparam int ENT_LAST_BIT = WORD_W + NB_W;
    localparam int ENT_W        = WORD_W + NB_W + 1;

    typedef struct packed {
        logic              last;
        logic [NB_W-1:0]   nbytes;
        logic [WORD_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/fifo_sync_ram.sv
// Single-clock FIFO on an inferred RAM (EBR or LUT RAM) with a registered read port.
// Latency: a word written to an empty FIFO can be popped the next cycle; rd_data/rd_valid one cycle after rd_en.
// Backpressure: writes while full and reads while empty are ignored; full/empty are exact.
//   clk, rst      : clock, synchronous active-high reset (pointers only, RAM is not cleared)
//   wr_en/wr_data : push request and data
//   rd_en         : pop request; rd_data holds the popped word until the next pop
//   rd_valid      : high for one cycle when rd_data has just been refreshed
//   full, empty   : occupancy flags
module fifo_sync_ram #(
    parameter int WIDTH      = 8,
    parameter int LOG2_DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << LOG2_DEPTH;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [LOG2_DEPTH:0] wr_ptr;
    logic [LOG2_DEPTH:0] rd_ptr;
    logic                wr_ok;
    logic                rd_ok;

    // Extra pointer bit distinguishes full from empty when the addresses match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[LOG2_DEPTH] != rd_ptr[LOG2_DEPTH]) &&
                   (wr_ptr[LOG2_DEPTH-1:0] == rd_ptr[LOG2_DEPTH-1:0]);
    assign wr_ok = wr_en & ~full;
    assign rd_ok = rd_en & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            rd_valid <= rd_ok;
        end
    end

    // RAM and its output register carry no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr[LOG2_DEPTH-1:0]] <= wr_data;
        if (rd_ok) rd_data <= mem[rd_ptr[LOG2_DEPTH-1:0]];
    end

endmodule

// File: rtl/acm_in_packer.sv
// Packs 32-bit fabric words into the muacm IN byte stream (LSB byte first) with packet last and idle flush.
// Latency: 2 cycles from an accepted write into an empty FIFO to in_valid; back-to-back words have no bubble.
// Backpressure: in_ready stalls the serializer with outputs held; w_ready drops when the word FIFO is full.
//   w_data/w_nbytes/w_last/w_valid/w_ready : word input (nbytes = valid bytes - 1)
//   in_data/in_last/in_valid/in_ready      : byte stream to muacm
//   in_flush_now : one-cycle flush after IDLE_FLUSH idle cycles with a partial packet outstanding
//   in_flush_time: constant FLUSH_TIME_EN;  busy: FIFO non-empty or a word being sent
module acm_in_packer
    import acm_pkg::*;
#(
    parameter int   FIFO_LOG2     = 3,
    parameter int   IDLE_FLUSH    = 1024,
    parameter logic FLUSH_TIME_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] w_data,
    input  logic [NB_W-1:0]   w_nbytes,
    input  logic              w_last,
    input  logic              w_valid,
    output logic              w_ready,
    output logic [BYTE_W-1:0] in_data,
    output logic              in_last,
    output logic              in_valid,
    input  logic              in_ready,
    output logic              in_flush_now,
    output logic              in_flush_time,
    output logic              busy
);

    localparam int             CNT_W    = (IDLE_FLUSH > 2) ? $clog2(IDLE_FLUSH) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'((IDLE_FLUSH > 0) ? IDLE_FLUSH - 1 : 0);
    localparam bit             TIMER_EN = (IDLE_FLUSH > 0);

    logic             fifo_full;
    logic             fifo_empty;
    logic             rd_valid;
    logic             pop;
    logic [ENT_W-1:0] wr_ent;
    logic [ENT_W-1:0] rd_ent;
    entry_t           head;

    logic [0:0]       state;
    logic [0:0]       state_d;
    logic [NB_W-1:0]  idx_q;
    logic [NB_W-1:0]  idx_cur;
    logic             last_byte;
    logic             fire;

    logic             pending;
    logic [CNT_W-1:0] cnt;

    assign w_ready       = ~rst & ~fifo_full;
    assign in_flush_time = FLUSH_TIME_EN;
    assign busy          = ~fifo_empty | (state == ST_SEND);

    assign wr_ent[ENT_DATA_LSB +: WORD_W] = w_data;
    assign wr_ent[ENT_NB_LSB +: NB_W]     = w_nbytes;
    assign wr_ent[ENT_LAST_BIT]           = w_last;

    // The FIFO output register doubles as the word register: it only changes on a pop.
    fifo_sync_ram #(
        .WIDTH      (ENT_W),
        .LOG2_DEPTH (FIFO_LOG2)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (w_valid & w_ready),
        .wr_data  (wr_ent),
        .rd_en    (pop),
        .rd_data  (rd_ent),
        .rd_valid (rd_valid),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign head = entry_t'(rd_ent);

    always_comb begin
        // A freshly popped word always starts at byte 0, whatever idx_q holds.
        idx_cur      = rd_valid ? '0 : idx_q;
        in_valid     = (state == ST_SEND);
        in_data      = head.data[BYTE_W*int'(idx_cur) +: BYTE_W];
        last_byte    = (idx_cur == head.nbytes);
        in_last      = in_valid & head.last & last_byte;
        fire         = in_valid & in_ready;
        pop          = ~fifo_empty & ((state == ST_IDLE) | (fire & last_byte));
        in_flush_now = TIMER_EN & pending & (cnt == '0) & ~in_valid;

        state_d = state;
        if (state == ST_IDLE) begin
            if (pop) state_d = ST_SEND;
        end else if (fire & last_byte & ~pop) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            idx_q   <= '0;
            pending <= 1'b0;
            cnt     <= '0;
        end else begin
            state <= state_d;
            idx_q <= fire ? idx_cur + 1'b1 : idx_cur;

            // Timer only runs down while a partial packet is outstanding and nothing is on the bus.
            if (fire) begin
                cnt     <= RELOAD;
                pending <= ~in_last;
            end else if (in_flush_now) begin
                pending <= 1'b0;
            end else if (pending && !in_valid && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_acm_in_packer.sv
// Self-checking bench for acm_in_packer: byte-queue scoreboard plus idle-flush model, directed and random stimulus.
// Latency: n/a.
// Backpressure: in_ready driven constant, toggling, random or manually per phase.
module tb_acm_in_packer;

    localparam int IDLE = 16;
    localparam int LOG2 = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] w_data = '0;
    logic [1:0]  w_nbytes = '0;
    logic        w_last = 1'b0;
    logic        w_valid = 1'b0;
    logic        w_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_valid;
    logic        in_ready = 1'b0;
    logic        in_flush_now;
    logic        in_flush_time;
    logic        busy;

    always #5 clk = ~clk;

    acm_in_packer #(
        .FIFO_LOG2     (LOG2),
        .IDLE_FLUSH    (IDLE),
        .FLUSH_TIME_EN (1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .w_data        (w_data),
        .w_nbytes      (w_nbytes),
        .w_last        (w_last),
        .w_valid       (w_valid),
        .w_ready       (w_ready),
        .in_data       (in_data),
        .in_last       (in_last),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_flush_now  (in_flush_now),
        .in_flush_time (in_flush_time),
        .busy          (busy)
    );

    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         rmode = 4;      // 0:ready 1:stall 2:toggle 3:random 4:manual
    logic [8:0] exp_q[$];       // {last, byte}
    int         fire_log[$];
    int         flush_cnt = 0;
    int         last_flush_cyc = 0;
    bit         pend_m = 1'b0;
    int         quiet_m = 0;
    bit         exp_flush;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk); #1;
        case (rmode)
            0: in_ready = 1'b1;
            1: in_ready = 1'b0;
            2: in_ready = ~in_ready;
            3: in_ready = 1'($urandom_range(0, 1));
            default: ;
        endcase
    end

    // Monitor: compares the byte stream and the flush pulse against the model.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            pend_m  = 1'b0;
            quiet_m = 0;
        end else begin
            // Flush due on the IDLE-th bus-idle cycle after the last byte of a partial packet.
            exp_flush = pend_m && !in_valid && (quiet_m == IDLE - 1);
            chk("flush_now", in_flush_now, exp_flush);
            if (in_flush_now) begin
                flush_cnt++;
                last_flush_cyc = cyc;
            end
            if (in_valid) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL spurious_byte: got in_valid=1 data %02h expected no byte", in_data);
                end else begin
                    chk("in_data", in_data, exp_q[0][7:0]);
                    chk("in_last", in_last, exp_q[0][8]);
                    if (in_ready) begin
                        pend_m  = !exp_q[0][8];
                        quiet_m = 0;
                        void'(exp_q.pop_front());
                        fire_log.push_back(cyc);
                    end
                end
            end
            if (!(in_valid && in_ready)) begin
                if (exp_flush) pend_m = 1'b0;
                if (!in_valid) quiet_m++;
            end
            if (w_valid && w_ready) begin
                for (int i = 0; i <= int'(w_nbytes); i++)
                    exp_q.push_back({(w_last && i == int'(w_nbytes)), 8'((w_data >> (8 * i)) & 32'hFF)});
            end
        end
    end

    task automatic send_word(input logic [31:0] d, input logic [1:0] nb, input logic l);
        bit done = 1'b0;
        w_data = d; w_nbytes = nb; w_last = l; w_valid = 1'b1;
        for (int k = 0; k < 2000 && !done; k++) begin
            @(negedge clk);
            done = w_ready && !rst;
            @(posedge clk); #1;
        end
        w_valid = 1'b0;
        chk("send_accepted", done, 1);
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int k = 0; k < 2000 && !done; k++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !busy;
            @(posedge clk); #1;
        end
        chk("drain", done, 1);
    endtask

    initial begin
        int f0, n0, n_acc, k;
        bit seen;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("w_ready_in_rst", w_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_w_ready", w_ready, 1);
        chk("rst_in_valid", in_valid, 0);
        chk("rst_in_last", in_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flush_now", in_flush_now, 0);
        chk("flush_time", in_flush_time, 1);
        @(posedge clk); #1;

        // 1: single 4-byte packet, 2-cycle latency, no flush
        rmode = 0;
        f0 = flush_cnt; n0 = fire_log.size();
        w_data = 32'h44332211; w_nbytes = 2'd3; w_last = 1'b1; w_valid = 1'b1;
        @(negedge clk); chk("t1_accept", w_ready, 1);
        @(posedge clk); #1; w_valid = 1'b0;
        @(negedge clk); chk("t1_lat_c1", in_valid, 0);
        @(negedge clk); chk("t1_lat_c2", in_valid, 1);
        @(posedge clk); #1;
        wait_drain();
        repeat (40) @(posedge clk); #1;
        chk("t1_bytes", fire_log.size() - n0, 4);
        chk("t1_consecutive", fire_log[n0+3] - fire_log[n0], 3);
        chk("t1_no_flush", flush_cnt - f0, 0);

        // 2: partial packet, flush IDLE cycles after the last byte
        f0 = flush_cnt;
        send_word(32'hAABBCCDD, 2'd1, 1'b0);
        wait_drain();
        repeat (IDLE + 10) @(posedge clk); #1;
        chk("t2_flush_count", flush_cnt - f0, 1);
        chk("t2_flush_delay", last_flush_cyc - fire_log[fire_log.size()-1], IDLE);

        // 3: fill while stalled; one word sits in the serializer so 2^LOG2+1 words are taken
        rmode = 4; in_ready = 1'b0;
        n_acc = 0; w_valid = 1'b1; w_nbytes = 2'd3; w_last = 1'b0;
        for (int i = 0; i < 20; i++) begin
            w_data = 32'h10203040 + 32'(n_acc) * 32'h01010101;
            @(negedge clk);
            if (w_ready) n_acc++;
            @(posedge clk); #1;
        end
        w_data = 32'h10203040 + 32'(n_acc) * 32'h01010101;
        chk("t3_accepted", n_acc, (1 << LOG2) + 1);
        @(negedge clk); chk("t3_full_w_ready", w_ready, 0);
        @(posedge clk); #1;
        in_ready = 1'b1;
        k = 0; seen = 1'b0;
        while (!seen && k < 50) begin
            @(negedge clk);
            if (w_ready) seen = 1'b1; else k++;
            @(posedge clk); #1;
        end
        w_valid = 1'b0;
        chk("t3_w_ready_after_pop", k, 4);
        rmode = 0;
        wait_drain();

        // 4: toggling in_ready during a 4-word packet
        rmode = 2; n0 = fire_log.size();
        send_word(32'h03020100, 2'd3, 1'b0);
        send_word(32'h07060504, 2'd3, 1'b0);
        send_word(32'h0B0A0908, 2'd3, 1'b0);
        send_word(32'h0F0E0D0C, 2'd3, 1'b1);
        wait_drain();
        chk("t4_bytes", fire_log.size() - n0, 16);

        // 5: reset mid-word with 3 words queued
        rmode = 4; in_ready = 1'b0;
        send_word(32'hA3A2A1A0, 2'd3, 1'b0);
        send_word(32'hB3B2B1B0, 2'd3, 1'b0);
        send_word(32'hC3C2C1C0, 2'd3, 1'b0);
        send_word(32'hD3D2D1D0, 2'd3, 1'b1);
        n0 = fire_log.size();
        in_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_ready = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t5_bytes_before_rst", fire_log.size() - n0, 2);
        @(negedge clk);
        chk("t5_in_valid", in_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_w_ready", w_ready, 1);
        @(posedge clk); #1;
        rmode = 0; n0 = fire_log.size();
        send_word(32'h000000EE, 2'd0, 1'b1);
        wait_drain();
        chk("t5_single_byte", fire_log.size() - n0, 1);

        // 6: back-to-back words, no bubble
        n0 = fire_log.size();
        send_word(32'h00000201, 2'd1, 1'b0);
        send_word(32'h00000003, 2'd0, 1'b1);
        wait_drain();
        chk("t6_bytes", fire_log.size() - n0, 3);
        chk("t6_no_bubble", fire_log[n0+2] - fire_log[n0], 2);

        // Random traffic under random backpressure
        rmode = 3;
        for (int i = 0; i < 40; i++) begin
            send_word($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        rmode = 0;
        wait_drain();
        repeat (IDLE + 5) @(posedge clk); #1;
        chk("final_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no end of test expected finish within 30000 cycles");
        $fatal(1);
    end

endmodule
